// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the radix-2 butterfly datapath.
// The helpers work on 64-bit values, so DATA_WIDTH is limited to 31 bits.
package fft_pkg;

    localparam int DW_DEFAULT         = 24;
    localparam int FFT_POINTS_DEFAULT = 16;
    localparam int TW_FRAC            = DW_DEFAULT - 2;

    typedef struct packed {
        logic signed [DW_DEFAULT-1:0] re;
        logic signed [DW_DEFAULT-1:0] im;
    } cplx_t;

    // Round half-up, then arithmetic shift right by sh bits. sh=0 returns v unchanged.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v,
                                                      input int                 sh);
        logic signed [63:0] half;
        if (sh <= 0) return v;
        half = 64'sd1 <<< (sh - 1);
        return (v + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int                 w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fft_butterfly_unit_cmplx_mult_pipe.sv
// Three-stage W*B pipeline: twiddle select, full-width products, round back to Q2.
// Operand A travels alongside so the butterfly stage sees it aligned with W*B.
module cmplx_mult_pipe
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEFAULT,
    parameter int DATA_WIDTH = DW_DEFAULT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  in_valid,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] tw_real,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] tw_imag,
    input  logic [$clog2(FFT_POINTS)-1:0]         tw_idx,
    input  logic signed [DATA_WIDTH-1:0]          a_re,
    input  logic signed [DATA_WIDTH-1:0]          a_im,
    input  logic signed [DATA_WIDTH-1:0]          b_re,
    input  logic signed [DATA_WIDTH-1:0]          b_im,
    output logic                                  out_valid,
    output logic signed [DATA_WIDTH-1:0]          a_re_d,
    output logic signed [DATA_WIDTH-1:0]          a_im_d,
    output logic signed [DATA_WIDTH:0]            p_re,
    output logic signed [DATA_WIDTH:0]            p_im
);

    localparam int FRAC = DATA_WIDTH - 2;
    localparam int PW   = 2 * DATA_WIDTH;

    logic                         s1_valid, s2_valid;
    logic signed [DATA_WIDTH-1:0] s1_a_re, s1_a_im, s1_b_re, s1_b_im, s1_wr, s1_wi;
    logic signed [DATA_WIDTH-1:0] s2_a_re, s2_a_im;
    logic signed [PW-1:0]         s2_rr, s2_ii, s2_ri, s2_ir;

    // NOTE: nonblocking assignments let each stage load the previous stage's old contents on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_a_re   <= '0;
            s1_a_im   <= '0;
            s1_b_re   <= '0;
            s1_b_im   <= '0;
            s1_wr     <= '0;
            s1_wi     <= '0;
            s2_valid  <= 1'b0;
            s2_a_re   <= '0;
            s2_a_im   <= '0;
            s2_rr     <= '0;
            s2_ii     <= '0;
            s2_ri     <= '0;
            s2_ir     <= '0;
            out_valid <= 1'b0;
            a_re_d    <= '0;
            a_im_d    <= '0;
            p_re      <= '0;
            p_im      <= '0;
        end else if (en) begin
            // The twiddle is captured here only, so later table changes cannot reach in-flight ops.
            s1_valid  <= in_valid;
            s1_a_re   <= a_re;
            s1_a_im   <= a_im;
            s1_b_re   <= b_re;
            s1_b_im   <= b_im;
            s1_wr     <= tw_real[tw_idx];
            s1_wi     <= tw_imag[tw_idx];

            s2_valid  <= s1_valid;
            s2_a_re   <= s1_a_re;
            s2_a_im   <= s1_a_im;
            s2_rr     <= PW'(s1_b_re) * PW'(s1_wr);
            s2_ii     <= PW'(s1_b_im) * PW'(s1_wi);
            s2_ri     <= PW'(s1_b_re) * PW'(s1_wi);
            s2_ir     <= PW'(s1_b_im) * PW'(s1_wr);

            // |W| <= 1 keeps the rounded product within DATA_WIDTH+1 bits, so no clamp is needed here.
            out_valid <= s2_valid;
            a_re_d    <= s2_a_re;
            a_im_d    <= s2_a_im;
            p_re      <= (DATA_WIDTH+1)'(round_shift(64'(s2_rr) - 64'(s2_ii), FRAC));
            p_im      <= (DATA_WIDTH+1)'(round_shift(64'(s2_ri) + 64'(s2_ir), FRAC));
        end
    end

endmodule

// File: rtl/fft_butterfly_unit.sv
// Pipelined radix-2 DIT butterfly: X0/X1 = (A +/- W*B) * 2^-SCALE, saturated,
// four stages that advance together under a single ready/valid enable.
module fft_butterfly_unit
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEFAULT,
    parameter int DATA_WIDTH = DW_DEFAULT,
    parameter int SCALE      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] tw_real,
    input  logic [FFT_POINTS-1:0][DATA_WIDTH-1:0] tw_imag,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [$clog2(FFT_POINTS)-1:0]         tw_idx,
    input  logic signed [DATA_WIDTH-1:0]          a_re,
    input  logic signed [DATA_WIDTH-1:0]          a_im,
    input  logic signed [DATA_WIDTH-1:0]          b_re,
    input  logic signed [DATA_WIDTH-1:0]          b_im,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [DATA_WIDTH-1:0]          x0_re,
    output logic signed [DATA_WIDTH-1:0]          x0_im,
    output logic signed [DATA_WIDTH-1:0]          x1_re,
    output logic signed [DATA_WIDTH-1:0]          x1_im,
    output logic                                  sat
);

    logic                         en, mp_valid, sat_any;
    logic signed [DATA_WIDTH-1:0] a_re_d, a_im_d;
    logic signed [DATA_WIDTH:0]   p_re, p_im;
    logic signed [63:0]           raw  [4];
    logic signed [63:0]           clip [4];

    // Whole pipe moves as one shift register: stall only when the output slot is full and blocked.
    assign en       = !out_valid || out_ready;
    assign in_ready = en || rst;

    cmplx_mult_pipe #(
        .FFT_POINTS (FFT_POINTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .tw_real   (tw_real),
        .tw_imag   (tw_imag),
        .tw_idx    (tw_idx),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .out_valid (mp_valid),
        .a_re_d    (a_re_d),
        .a_im_d    (a_im_d),
        .p_re      (p_re),
        .p_im      (p_im)
    );

    // NOTE: sat_any is defaulted before the loop so this block never infers a latch.
    always_comb begin
        sat_any = 1'b0;
        raw[0]  = round_shift(64'(a_re_d) + 64'(p_re), SCALE);
        raw[1]  = round_shift(64'(a_im_d) + 64'(p_im), SCALE);
        raw[2]  = round_shift(64'(a_re_d) - 64'(p_re), SCALE);
        raw[3]  = round_shift(64'(a_im_d) - 64'(p_im), SCALE);
        for (int i = 0; i < 4; i++) begin
            clip[i] = saturate(raw[i], DATA_WIDTH);
            sat_any = sat_any | (clip[i] != raw[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sat       <= 1'b0;
            x0_re     <= '0;
            x0_im     <= '0;
            x1_re     <= '0;
            x1_im     <= '0;
        end else if (en) begin
            out_valid <= mp_valid;
            sat       <= sat_any;
            x0_re     <= DATA_WIDTH'(clip[0]);
            x0_im     <= DATA_WIDTH'(clip[1]);
            x1_re     <= DATA_WIDTH'(clip[2]);
            x1_im     <= DATA_WIDTH'(clip[3]);
        end
    end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Directed bench for fft_butterfly_unit: a SCALE=1 and a SCALE=0 instance share the stimulus.
module tb_fft_butterfly_unit;
    import fft_pkg::*;

    localparam int N  = FFT_POINTS_DEFAULT;
    localparam int W  = DW_DEFAULT;
    localparam int IW = $clog2(N);

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][W-1:0] tw_real, tw_imag;
    logic                in_valid, out_ready;
    logic [IW-1:0]       tw_idx;
    logic signed [W-1:0] a_re, a_im, b_re, b_im;

    logic                in_ready, out_valid, sat;
    logic signed [W-1:0] x0_re, x0_im, x1_re, x1_im;
    logic                in_ready_u, out_valid_u, sat_u;
    logic signed [W-1:0] x0_re_u, x0_im_u, x1_re_u, x1_im_u;

    int tw_re_i [N];
    int tw_im_i [N];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fft_butterfly_unit #(.FFT_POINTS(N), .DATA_WIDTH(W), .SCALE(1)) dut (
        .clk(clk), .rst(rst), .tw_real(tw_real), .tw_imag(tw_imag),
        .in_valid(in_valid), .in_ready(in_ready), .tw_idx(tw_idx),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im), .sat(sat)
    );

    fft_butterfly_unit #(.FFT_POINTS(N), .DATA_WIDTH(W), .SCALE(0)) dut_u (
        .clk(clk), .rst(rst), .tw_real(tw_real), .tw_imag(tw_imag),
        .in_valid(in_valid), .in_ready(in_ready_u), .tw_idx(tw_idx),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid_u), .out_ready(out_ready),
        .x0_re(x0_re_u), .x0_im(x0_im_u), .x1_re(x1_re_u), .x1_im(x1_im_u), .sat(sat_u)
    );

    typedef struct {
        int    k;
        int    scale;
        cplx_t a, b, x0, x1;
        bit    s;
    } vec_t;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic cplx_t cx(input int re, input int im);
        cplx_t c;
        c.re = W'(re);
        c.im = W'(im);
        return c;
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    // Reference butterfly straight from the fixed-point definition, in 64-bit integers.
    function automatic void model(input int k, input int scale, input cplx_t a, input cplx_t b,
                                  output cplx_t x0, output cplx_t x1, output bit s);
        longint wr, wi, pr, pi, half, hi, lo;
        longint r [4];
        wr   = tw_re_i[k];
        wi   = tw_im_i[k];
        half = longint'(1) <<< (TW_FRAC - 1);
        pr   = (longint'($signed(b.re)) * wr - longint'($signed(b.im)) * wi + half) >>> TW_FRAC;
        pi   = (longint'($signed(b.re)) * wi + longint'($signed(b.im)) * wr + half) >>> TW_FRAC;
        r[0] = longint'($signed(a.re)) + pr;
        r[1] = longint'($signed(a.im)) + pi;
        r[2] = longint'($signed(a.re)) - pr;
        r[3] = longint'($signed(a.im)) - pi;
        hi   = (longint'(1) <<< (W - 1)) - 1;
        lo   = -(longint'(1) <<< (W - 1));
        s    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (scale != 0) r[i] = (r[i] + 1) >>> 1;
            if (r[i] > hi) begin r[i] = hi; s = 1'b1; end
            if (r[i] < lo) begin r[i] = lo; s = 1'b1; end
        end
        x0 = cx(int'(r[0]), int'(r[1]));
        x1 = cx(int'(r[2]), int'(r[3]));
    endfunction

    task automatic drive(input int k, input cplx_t a, input cplx_t b);
        tw_idx = IW'(k);
        a_re   = a.re;
        a_im   = a.im;
        b_re   = b.re;
        b_im   = b.im;
    endtask

    task automatic check_out(input string tag, input int scale, input cplx_t x0e,
                             input cplx_t x1e, input bit se);
        if (scale != 0) begin
            check({tag, "_x0_re"}, x0_re, x0e.re);
            check({tag, "_x0_im"}, x0_im, x0e.im);
            check({tag, "_x1_re"}, x1_re, x1e.re);
            check({tag, "_x1_im"}, x1_im, x1e.im);
            check({tag, "_sat"},   sat,   se);
        end else begin
            check({tag, "_u_x0_re"}, x0_re_u, x0e.re);
            check({tag, "_u_x0_im"}, x0_im_u, x0e.im);
            check({tag, "_u_x1_re"}, x1_re_u, x1e.re);
            check({tag, "_u_x1_im"}, x1_im_u, x1e.im);
            check({tag, "_u_sat"},   sat_u,   se);
        end
    endtask

    // One op into an idle pipe; checks latency and result. poke rewrites twiddle 0 after S1 sampled it.
    task automatic issue_and_collect(input string tag, input int k, input int scale, input cplx_t a,
                                     input cplx_t b, input cplx_t x0e, input cplx_t x1e,
                                     input bit se, input bit poke);
        int lat;
        @(negedge clk);
        drive(k, a, b);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (poke) begin
            tw_real[0] = W'(0);
            tw_imag[0] = W'(12345);
        end
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 4);
        check_out(tag, scale, x0e, x1e, se);
    endtask

    vec_t  vecs [7];
    int    sk [8];
    cplx_t sa [8], sb [8], e0s [8], e1s [8], e0u [8], e1u [8];
    bit    ess [8], esu [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int  sent, rcvd;
        bit  seen;
        real ang;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(0, cx(0, 0), cx(0, 0));
        for (int i = 0; i < N; i++) begin
            ang        = 2.0 * 3.14159265358979323846 * i / N;
            tw_re_i[i] = rnd($cos(ang) * 4194304.0);
            tw_im_i[i] = rnd(-$sin(ang) * 4194304.0);
            tw_real[i] = W'(tw_re_i[i]);
            tw_imag[i] = W'(tw_im_i[i]);
        end

        vecs[0] = '{k: 0,  scale: 1, a: cx(1000, 0),       b: cx(200, 0),
                    x0: cx(600, 0),      x1: cx(400, 0),       s: 1'b0};
        vecs[1] = '{k: 4,  scale: 1, a: cx(1000, 0),       b: cx(200, 0),
                    x0: cx(500, -100),   x1: cx(500, 100),     s: 1'b0};
        vecs[2] = '{k: 0,  scale: 0, a: cx(8388607, -8388608), b: cx(8388607, -8388608),
                    x0: cx(8388607, -8388608), x1: cx(0, 0),  s: 1'b1};
        vecs[3] = '{k: 0,  scale: 1, a: cx(3, -3),         b: cx(0, 0),
                    x0: cx(2, -1),       x1: cx(2, -1),        s: 1'b0};
        vecs[4] = '{k: 8,  scale: 1, a: cx(100, 50),       b: cx(20, -10),
                    x0: cx(40, 30),      x1: cx(60, 20),       s: 1'b0};
        vecs[5] = '{k: 12, scale: 0, a: cx(10, 20),        b: cx(3, 4),
                    x0: cx(6, 23),       x1: cx(14, 17),       s: 1'b0};
        vecs[6] = '{k: 0,  scale: 0, a: cx(-8388608, 100), b: cx(-1, -200),
                    x0: cx(-8388608, -100), x1: cx(-8388607, 300), s: 1'b1};

        for (int i = 0; i < 8; i++) begin
            sk[i] = 2 * i;
            sa[i] = cx(i * 1111 - 4000, 3000 - i * 777);
            sb[i] = cx(i * 555 - 2000, i * 333 - 1000);
        end
        sa[1] = cx(8388607, 8388607);
        sb[1] = cx(8388607, -8388608);
        sa[6] = cx(-8388608, -8388608);
        sb[6] = cx(-8388608, 8388607);
        for (int i = 0; i < 8; i++) begin
            model(sk[i], 1, sa[i], sb[i], e0s[i], e1s[i], ess[i]);
            model(sk[i], 0, sa[i], sb[i], e0u[i], e1u[i], esu[i]);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_valid_u", out_valid_u, 0);
        check("rst_sat", sat, 0);
        check("rst_x0_re", x0_re, 0);
        check("rst_x1_im", x1_im, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        foreach (vecs[i])
            issue_and_collect($sformatf("vec%0d", i), vecs[i].k, vecs[i].scale, vecs[i].a,
                              vecs[i].b, vecs[i].x0, vecs[i].x1, vecs[i].s, 1'b0);

        issue_and_collect("tw_change", 0, 1, cx(1000, 0), cx(200, 0), cx(600, 0), cx(400, 0),
                          1'b0, 1'b1);
        tw_real[0] = W'(tw_re_i[0]);
        tw_imag[0] = W'(tw_im_i[0]);

        // Back-to-back stream with the sink stalled in cycles 5..7
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 8) begin
                drive(sk[sent], sa[sent], sb[sent]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) begin
                check($sformatf("stall_c%0d_in_ready", cyc), in_ready, 0);
                check_out($sformatf("stall_c%0d", cyc), 1, e0s[rcvd], e1s[rcvd], ess[rcvd]);
            end
            if (out_valid && out_ready) begin
                check_out($sformatf("stream%0d", rcvd), 1, e0s[rcvd], e1s[rcvd], ess[rcvd]);
                check_out($sformatf("stream%0d", rcvd), 0, e0u[rcvd], e1u[rcvd], esu[rcvd]);
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        check("stream_received", rcvd, 8);
        check("stream_sent", sent, 8);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);

        // Reset with three ops in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(sk[i], sa[i], sb[i]);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", in_ready, 1);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || out_valid_u) seen = 1'b1;
        end
        check("rst_flush_no_output", seen, 0);
        issue_and_collect("post_rst", 0, 1, cx(1000, 0), cx(200, 0), cx(600, 0), cx(400, 0),
                          1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fft_butterfly_unit.md
Name: fft_butterfly_unit

Overview:
- Pipelined radix-2 DIT butterfly. Consumes the twiddle cos/-sin arrays driven by the twiddle lookup block and selects one factor per operation by index.
- Computes X0 = (A + W·B)·2^-SCALE and X1 = (A − W·B)·2^-SCALE, with W = tw_real[k] + j·tw_imag[k].
- Sits between the FFT stage controller/sample memory and the memory write-back.
- Fully pipelined: one butterfly per cycle, with ready/valid backpressure.

Parameters:
- FFT_POINTS, 16, transform size; sets the twiddle array depth and index width.
- DATA_WIDTH, 24, width of each signed sample and twiddle component.
- SCALE, 1, right-shift applied at the output: 1 = divide by 2 per stage; 0 = no scaling.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- tw_real  in  DATA_WIDTH x FFT_POINTS  signed cos(2πi/N) array, Q2.(DATA_WIDTH-2), so 1.0 = 2^(DATA_WIDTH-2).
- tw_imag  in  DATA_WIDTH x FFT_POINTS  signed −sin(2πi/N) array, same format.
- in_valid  in  1  operands valid.
- in_ready  out  1  unit accepts operands this cycle.
- tw_idx  in  $clog2(FFT_POINTS)  twiddle index k.
- a_re, a_im, b_re, b_im  in  DATA_WIDTH each  signed operands A and B.
- out_valid  out  1  results valid.
- out_ready  in  1  downstream accepts results.
- x0_re, x0_im, x1_re, x1_im  out  DATA_WIDTH each  signed results X0 and X1.
- sat  out  1  asserted with out_valid when any output component saturated.

Behaviour:
- Reset: all pipeline valid bits cleared; out_valid=0; sat=0; all data outputs 0. in_ready=1 during reset.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. Transfer occurs when in_valid && in_ready.
- All four stages advance together when en=1 and hold their contents when en=0. No bubble collapsing.
- Latency is 4 cycles from accepted input to out_valid when no stalls occur. Throughput is 1 per cycle.
- S1: register A, B and tw_idx; register the selected twiddle wr=tw_real[k], wi=tw_imag[k]. Every k in 0..FFT_POINTS-1 is legal; there is no range check.
- S2: form four full products br·wr, bi·wi, br·wi, bi·wr, each 2·DATA_WIDTH bits signed.
- S3:
  - p_re = br·wr − bi·wi; p_im = br·wi + bi·wr, each 2·DATA_WIDTH+1 bits.
  - Round half-up: add 2^(DATA_WIDTH-3), then arithmetic right shift by DATA_WIDTH-2.
  - Keep DATA_WIDTH+1 bits with no saturation. The range is safe because |W| ≤ 1.
- S4:
  - Compute sum/diff A ± WB in DATA_WIDTH+2 bits.
  - If SCALE=1: add 1, then arithmetic right shift by 1 (round half-up).
  - Saturate each component to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1].
  - sat = OR of the four per-component saturation flags.
- The valid bit travels alongside each stage. Output data and sat are don't-care while out_valid=0 but must not be X after reset.
- Simultaneous input accept and output drain with out_valid=1 and out_ready=1 is legal and sustains full throughput.
- A stall (out_ready=0 with out_valid=1) freezes every stage; outputs stay stable until accepted.
- Reset asserted mid-operation discards all in-flight butterflies on the next edge. No partial output is emitted.
- Twiddle arrays are sampled only in S1; changing them afterwards does not affect in-flight operations.

Decomposition:
- Package fft_pkg holds:
  - typedef cplx_t {signed re, im} of DATA_WIDTH;
  - localparam TW_FRAC = DATA_WIDTH-2;
  - a saturate function;
  - a round-shift function.
- One sub-module, cmplx_mult_pipe, covers S1–S3 (twiddle select, multiply, round). It has an enable input and 3-cycle latency. fft_butterfly_unit adds S4 and the handshake.

Test Plan:
- W=1 (k=0), SCALE=1, A=(1000,0), B=(200,0) → after 4 cycles X0=(600,0), X1=(400,0), sat=0.
- k=4 with FFT_POINTS=16 (W=−j), A=(1000,0), B=(200,0) → X0=(500,−100), X1=(500,100).
- SCALE=0, k=0, A=B=(8388607,−8388608) → X0=(8388607,−8388608) saturated, X1=(0,0), sat=1.
- Back-to-back stream of 8 inputs with out_ready held 0 for cycles 5–7 → in_ready drops during the stall, no data lost or duplicated, all 8 results emerge in order, each matching a golden model.
- Rounding: k=0, SCALE=1, A=(3,−3), B=(0,0) → X0=X1=(2,−1) (half-up rounding).
- Fill the pipeline with 3 ops, assert rst for 1 cycle → out_valid stays 0 until new inputs arrive; the first post-reset result appears exactly 4 cycles after its accept.
